// File: rtl/tile_config_frame_mem.sv
// Double-buffered tile configuration frame memory.
// Frames are captured into a shadow array on FrameStrobe rising edges with an
// even-parity check; Commit copies shadow to the active array that drives
// ConfigBits. Active frames can be read back one frame at a time.
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   FrameData/Parity    frame payload and its even-parity bit
//   FrameStrobe         one strobe per frame, rising edge writes
//   Commit / ClearErr   shadow->active copy request / clear parity error
//   ReadReq / ReadSel   readback request and frame index
//   ReadData/ReadValid  readback frame (active array), 1-cycle valid pulse
//   CommitDone          1-cycle pulse after a successful commit
//   ParityErr/ErrFrame  sticky parity failure flag and first failing frame
//   ConfigBits(_N)      active configuration bits and their inverse
module tile_config_frame_mem #(
  parameter int unsigned MAX_FRAMES_PER_COL = 20,
  parameter int unsigned FRAME_BITS_PER_ROW = 32,
  parameter int unsigned NO_CONFIG_BITS     = 640,
  parameter logic [MAX_FRAMES_PER_COL*FRAME_BITS_PER_ROW-1:0] RESET_BITSTREAM = '0,
  parameter int unsigned SEL_W              = $clog2(MAX_FRAMES_PER_COL)
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [FRAME_BITS_PER_ROW-1:0] FrameData,
  input  logic                          FrameParity,
  input  logic [MAX_FRAMES_PER_COL-1:0] FrameStrobe,
  input  logic                          Commit,
  input  logic                          ClearErr,
  input  logic                          ReadReq,
  input  logic [SEL_W-1:0]              ReadSel,
  output logic [FRAME_BITS_PER_ROW-1:0] ReadData,
  output logic                          ReadValid,
  output logic                          CommitDone,
  output logic                          ParityErr,
  output logic [SEL_W-1:0]              ErrFrame,
  output logic [NO_CONFIG_BITS-1:0]     ConfigBits,
  output logic [NO_CONFIG_BITS-1:0]     ConfigBits_N
);

  localparam int unsigned TOTAL_BITS = MAX_FRAMES_PER_COL * FRAME_BITS_PER_ROW;

  logic [TOTAL_BITS-1:0]         r_shadow;
  logic [TOTAL_BITS-1:0]         r_active;
  logic [MAX_FRAMES_PER_COL-1:0] r_strobe_q;
  logic [FRAME_BITS_PER_ROW-1:0] r_read_data;
  logic                          r_read_valid;
  logic                          r_commit_done;
  logic                          r_parity_err;
  logic [SEL_W-1:0]              r_err_frame;

  logic [MAX_FRAMES_PER_COL-1:0] w_rise;
  logic                          w_any_rise;
  logic                          w_parity_ok;
  logic [SEL_W-1:0]              w_low_fail;
  logic [TOTAL_BITS-1:0]         w_shadow_next;
  logic [FRAME_BITS_PER_ROW-1:0] w_read_frame;

  assign w_rise      = FrameStrobe & ~r_strobe_q;
  assign w_any_rise  = |w_rise;
  assign w_parity_ok = ~(^FrameData ^ FrameParity);

  // Lowest rising strobe index, reported as the failing frame
  always_comb begin
    w_low_fail = '0;
    for (int f = MAX_FRAMES_PER_COL - 1; f >= 0; f--) begin
      if (w_rise[f]) w_low_fail = SEL_W'(f);
    end
  end

  // Broadcast FrameData into every frame whose strobe just rose
  always_comb begin
    w_shadow_next = r_shadow;
    for (int f = 0; f < MAX_FRAMES_PER_COL; f++) begin
      if (w_rise[f]) w_shadow_next[f*FRAME_BITS_PER_ROW +: FRAME_BITS_PER_ROW] = FrameData;
    end
  end

  // Readback mux; out-of-range selects fall through to zero
  always_comb begin
    w_read_frame = '0;
    for (int f = 0; f < MAX_FRAMES_PER_COL; f++) begin
      if (ReadSel == SEL_W'(f)) w_read_frame = r_active[f*FRAME_BITS_PER_ROW +: FRAME_BITS_PER_ROW];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_shadow      <= RESET_BITSTREAM;
      r_active      <= RESET_BITSTREAM;
      r_strobe_q    <= '0;
      r_read_data   <= '0;
      r_read_valid  <= 1'b0;
      r_commit_done <= 1'b0;
      r_parity_err  <= 1'b0;
      r_err_frame   <= '0;
    end else begin
      r_strobe_q    <= FrameStrobe;
      r_read_valid  <= ReadReq;
      r_commit_done <= 1'b0;
      if (ReadReq) r_read_data <= w_read_frame;
      // Commit copies the pre-edge shadow, so same-cycle writes stay uncommitted
      if (Commit && !r_parity_err) begin
        r_active      <= r_shadow;
        r_commit_done <= 1'b1;
      end
      if (w_any_rise && w_parity_ok) r_shadow <= w_shadow_next;
      // A new failure beats a same-cycle ClearErr; otherwise the first error is kept
      if (w_any_rise && !w_parity_ok) begin
        r_parity_err <= 1'b1;
        if (!r_parity_err || ClearErr) r_err_frame <= w_low_fail;
      end else if (ClearErr) begin
        r_parity_err <= 1'b0;
        r_err_frame  <= '0;
      end
    end
  end

  assign ReadData     = r_read_data;
  assign ReadValid    = r_read_valid;
  assign CommitDone   = r_commit_done;
  assign ParityErr    = r_parity_err;
  assign ErrFrame     = r_err_frame;
  assign ConfigBits   = r_active[NO_CONFIG_BITS-1:0];
  assign ConfigBits_N = ~r_active[NO_CONFIG_BITS-1:0];

endmodule

// File: tb/tb_tile_config_frame_mem.sv
// Directed bench for tile_config_frame_mem with a reference model and a
// readback scoreboard.
module tb_tile_config_frame_mem;

  localparam int unsigned NF  = 20;
  localparam int unsigned FB  = 32;
  localparam int unsigned NCB = 640;
  localparam int unsigned SW  = 5;
  localparam logic [NF*FB-1:0] RST_BS = {80{8'hA5}};

  logic           CLK;
  logic           RST;
  logic [FB-1:0]  FrameData;
  logic           FrameParity;
  logic [NF-1:0]  FrameStrobe;
  logic           Commit;
  logic           ClearErr;
  logic           ReadReq;
  logic [SW-1:0]  ReadSel;
  logic [FB-1:0]  ReadData;
  logic           ReadValid;
  logic           CommitDone;
  logic           ParityErr;
  logic [SW-1:0]  ErrFrame;
  logic [NCB-1:0] ConfigBits;
  logic [NCB-1:0] ConfigBits_N;

  tile_config_frame_mem #(
    .MAX_FRAMES_PER_COL(NF),
    .FRAME_BITS_PER_ROW(FB),
    .NO_CONFIG_BITS(NCB),
    .RESET_BITSTREAM(RST_BS)
  ) dut (
    .CLK(CLK), .RST(RST), .FrameData(FrameData), .FrameParity(FrameParity),
    .FrameStrobe(FrameStrobe), .Commit(Commit), .ClearErr(ClearErr),
    .ReadReq(ReadReq), .ReadSel(ReadSel), .ReadData(ReadData),
    .ReadValid(ReadValid), .CommitDone(CommitDone), .ParityErr(ParityErr),
    .ErrFrame(ErrFrame), .ConfigBits(ConfigBits), .ConfigBits_N(ConfigBits_N)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model state
  logic [FB-1:0] m_shadow [NF];
  logic [FB-1:0] m_active [NF];
  logic [NF-1:0] m_sq;
  logic          m_perr;
  logic [SW-1:0] m_ef;
  logic [FB-1:0] m_rd;
  logic          exp_valid;
  logic          exp_cd;
  logic [FB-1:0] sb [$];

  task automatic chk(input string tag, input logic [NCB-1:0] obs, input logic [NCB-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NCB-1:0] flat_active();
    logic [NF*FB-1:0] v;
    for (int f = 0; f < NF; f++) v[f*FB +: FB] = m_active[f];
    return v[NCB-1:0];
  endfunction

  // Advance the model by one edge using current inputs, then clock and compare
  task automatic tick();
    logic [NF-1:0] rise;
    logic [FB-1:0] rd;
    if (RST) begin
      for (int f = 0; f < NF; f++) begin
        m_shadow[f] = RST_BS[f*FB +: FB];
        m_active[f] = RST_BS[f*FB +: FB];
      end
      m_sq = '0; m_perr = 1'b0; m_ef = '0; m_rd = '0;
      exp_valid = 1'b0; exp_cd = 1'b0;
      sb.delete();
    end else begin
      rise = FrameStrobe & ~m_sq;
      m_sq = FrameStrobe;
      exp_valid = ReadReq;
      if (ReadReq) begin
        rd = (ReadSel < SW'(NF)) ? m_active[ReadSel] : '0;
        sb.push_back(rd);
        m_rd = rd;
      end
      exp_cd = Commit && !m_perr;
      if (exp_cd) for (int f = 0; f < NF; f++) m_active[f] = m_shadow[f];
      if (rise != '0) begin
        if ((^FrameData ^ FrameParity) == 1'b0) begin
          for (int f = 0; f < NF; f++) if (rise[f]) m_shadow[f] = FrameData;
        end else begin
          if (!m_perr || ClearErr)
            for (int f = NF - 1; f >= 0; f--) if (rise[f]) m_ef = SW'(f);
          m_perr = 1'b1;
        end
      end else if (ClearErr) begin
        m_perr = 1'b0; m_ef = '0;
      end
    end
    @(posedge CLK); #1;
    chk("config_bits", ConfigBits, flat_active());
    chk("config_bits_n", ConfigBits_N, ~flat_active());
    chk("commit_done", NCB'(CommitDone), NCB'(exp_cd));
    chk("parity_err", NCB'(ParityErr), NCB'(m_perr));
    chk("err_frame", NCB'(ErrFrame), NCB'(m_ef));
    chk("read_valid", NCB'(ReadValid), NCB'(exp_valid));
    if (ReadValid === 1'b1 && sb.size() > 0) chk("read_data", NCB'(ReadData), NCB'(sb.pop_front()));
    else chk("read_hold", NCB'(ReadData), NCB'(m_rd));
  endtask

  task automatic drive_frame(input logic [NF-1:0] strobe, input logic [FB-1:0] data, input bit good);
    FrameStrobe = strobe;
    FrameData   = data;
    FrameParity = good ? ^data : ~(^data);
  endtask

  task automatic read_frame(input logic [SW-1:0] sel);
    ReadReq = 1'b1; ReadSel = sel;
    tick();
    ReadReq = 1'b0;
  endtask

  task automatic do_commit();
    Commit = 1'b1;
    tick();
    Commit = 1'b0;
  endtask

  initial begin
    RST = 1'b1; FrameData = '0; FrameParity = 1'b0; FrameStrobe = '0;
    Commit = 1'b0; ClearErr = 1'b0; ReadReq = 1'b0; ReadSel = '0;
    m_sq = '0; m_perr = 1'b0; m_ef = '0; m_rd = '0; exp_valid = 1'b0; exp_cd = 1'b0;
    #1;
    // T1 reset
    tick(); tick();
    RST = 1'b0;
    tick();
    chk("t1_cfg_pattern", ConfigBits, RST_BS[NCB-1:0]);
    chk("t1_cfg_n_pattern", ConfigBits_N, ~RST_BS[NCB-1:0]);
    chk("t1_flags", NCB'({ReadValid, CommitDone, ParityErr, ErrFrame}), '0);

    // T2 write frame 3 then commit
    drive_frame(NF'(1) << 3, 32'hDEADBEEF, 1);
    tick();
    drive_frame('0, 32'h0, 1);
    tick();
    chk("t2_before_commit", NCB'(ConfigBits[127:96]), NCB'(32'hA5A5A5A5));
    do_commit();
    chk("t2_frame3", NCB'(ConfigBits[127:96]), NCB'(32'hDEADBEEF));
    chk("t2_cdone_pulse", NCB'(CommitDone), NCB'(1'b1));
    tick();
    chk("t2_cdone_drop", NCB'(CommitDone), NCB'(1'b0));

    // T3 held strobe writes only the first-cycle data
    for (int i = 0; i < 4; i++) begin
      drive_frame(NF'(1) << 5, 32'h11111111 * (i + 1), 1);
      tick();
    end
    drive_frame('0, 32'h0, 1);
    tick();
    do_commit();
    read_frame(SW'(5));
    chk("t3_held_strobe", NCB'(ReadData), NCB'(32'h11111111));

    // Broadcast to frames 10 and 11
    drive_frame((NF'(1) << 10) | (NF'(1) << 11), 32'h0BADF00D, 1);
    tick();
    drive_frame('0, 32'h0, 1);
    do_commit();
    chk("bcast_f10", NCB'(ConfigBits[351:320]), NCB'(32'h0BADF00D));
    chk("bcast_f11", NCB'(ConfigBits[383:352]), NCB'(32'h0BADF00D));

    // T4 parity failures: first error kept, commit blocked
    drive_frame(NF'(1) << 7, 32'h00000001, 0);
    tick();
    drive_frame(NF'(1) << 2, 32'h00000003, 0);
    tick();
    drive_frame('0, 32'h0, 1);
    tick();
    chk("t4_perr", NCB'(ParityErr), NCB'(1'b1));
    chk("t4_err_frame", NCB'(ErrFrame), NCB'(7));
    do_commit();
    chk("t4_commit_blocked", NCB'(CommitDone), NCB'(1'b0));
    // ClearErr with a coincident failure: new failure index wins
    ClearErr = 1'b1;
    drive_frame(NF'(1) << 9, 32'h00000007, 0);
    tick();
    ClearErr = 1'b0;
    drive_frame('0, 32'h0, 1);
    chk("t4_clear_collide", NCB'(ErrFrame), NCB'(9));
    ClearErr = 1'b1;
    tick();
    ClearErr = 1'b0;
    chk("t4_cleared", NCB'({ParityErr, ErrFrame}), '0);
    do_commit();
    chk("t4_commit_ok", NCB'(CommitDone), NCB'(1'b1));

    // T5 readback
    read_frame(SW'(3));
    chk("t5_rd3", NCB'(ReadData), NCB'(32'hDEADBEEF));
    read_frame(SW'(25));
    chk("t5_rd25", NCB'({ReadValid, ReadData}), NCB'({1'b1, 32'h0}));
    read_frame(SW'(2));
    tick(); tick();
    chk("t5_hold", NCB'(ReadData), NCB'(32'hA5A5A5A5));
    // Readback coincident with commit returns pre-commit data
    drive_frame(NF'(1) << 4, 32'h12345678, 1);
    tick();
    drive_frame('0, 32'h0, 1);
    Commit = 1'b1; ReadReq = 1'b1; ReadSel = SW'(4);
    tick();
    Commit = 1'b0; ReadReq = 1'b0;
    chk("t5_rd_pre_commit", NCB'(ReadData), NCB'(32'hA5A5A5A5));
    read_frame(SW'(4));
    chk("t5_rd_post_commit", NCB'(ReadData), NCB'(32'h12345678));

    // T6 commit coincident with strobe frame 0
    drive_frame(NF'(1), 32'hCAFEF00D, 1);
    Commit = 1'b1;
    tick();
    Commit = 1'b0;
    drive_frame('0, 32'h0, 1);
    chk("t6_f0_not_active", NCB'(ConfigBits[31:0]), NCB'(32'hA5A5A5A5));
    do_commit();
    chk("t6_f0_active", NCB'(ConfigBits[31:0]), NCB'(32'hCAFEF00D));
    // Reset mid-load discards shadow writes
    drive_frame(NF'(1) << 1, 32'h55AA55AA, 1);
    tick();
    drive_frame('0, 32'h0, 1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    tick();
    do_commit();
    read_frame(SW'(1));
    chk("t6_rst_discard", NCB'(ReadData), NCB'(32'hA5A5A5A5));
    chk("t6_rst_cfg", ConfigBits, RST_BS[NCB-1:0]);

    chk("sb_empty", NCB'(sb.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
